axi_counter_core: RTL and testbench
===================================

# axi_counter_core

- Programmable counter engine fed by the AXI register bank's control words; produces the 3-bit status word that the register bank reads back through its status slot.
- Features: prescaled up/down counting between a load value and a limit, one-shot or auto-reload, pause/resume, soft clear and an optional terminal-count interrupt.

## Interface
- DATA_WIDTH, 32, width of register words and of the counter.
- clk  in  1  clock.
- areset  in  1  reset, asynchronous, active-low.
- ctrl_i  in  DATA_WIDTH  CTRL word (register 0):
  - bit0 EN (level).
  - bit1 DIR (0 up, 1 down).
  - bit2 ONESHOT.
  - bit3 CLR (rising edge acts).
- load_i  in  DATA_WIDTH  LOAD value (register 1).
- limit_i  in  DATA_WIDTH  terminal value (register 2).
- presc_i  in  DATA_WIDTH  prescaler; one count step every presc_i+1 clocks (register 3).
- irqen_i  in  DATA_WIDTH  bit0 enables irq_o (register 4).
- status_o  out  3  status bits:
  - [0] RUNNING.
  - [1] DONE.
  - [2] WRAPPED (sticky).
- count_o  out  DATA_WIDTH  current count.
- irq_o  out  1  terminal-count pulse.

## Operation
- FSM states: IDLE, RUN, PAUSE, DONE.
- IDLE:
  - EN=1 → RUN; count←load_i; prescaler←0.
- RUN:
  - Prescaler counts 0..presc_i and emits a one-cycle tick at presc_i, then returns to 0.
  - On tick, if count≠limit_i: count←count±1, modulo 2^DATA_WIDTH.
  - On tick, if count==limit_i (terminal event):
    - ONESHOT=1: → DONE; DONE←1; count holds at limit_i.
    - ONESHOT=0: count←load_i; WRAPPED←1; stay in RUN.
  - EN=0 → PAUSE; count and prescaler hold.
- PAUSE:
  - EN=1 → RUN; resume from the held count and prescaler.
- DONE:
  - Count holds.
  - EN=0 → IDLE; DONE←0.
- CLR rising edge (ctrl_i[3] previous 0, now 1), from any state, highest priority:
  - count←load_i, prescaler←0, DONE←0, WRAPPED←0, state←IDLE.
  - If EN is still 1, the FSM re-enters RUN on the next cycle.
- Input sampling:
  - presc_i, limit_i and DIR are read live every cycle.
  - load_i is used only at load, reload and clear events.
  - presc_i lowered below the current prescaler value: the prescaler wraps through 2^DATA_WIDTH before ticking; software avoids this by pausing first.
- RUNNING = (state==RUN).
- WRAPPED clears only via CLR or reset.

## Timing
- All outputs registered.
- Reset values: state IDLE, count_o 0, status_o 3'b000, irq_o 0, prescaler 0, CLR edge register 0.
- Enable latency:
  - EN sampled high at edge N → RUN with count_o=load_i visible after edge N.
  - First step at edge N+presc_i+1.
- presc_i=0: one step per clock.
- Terminal event at edge T:
  - count_o, status_o and irq_o update after edge T.
  - irq_o high for exactly one cycle.
- EN deassert in the same cycle as a tick: the pause wins and the tick is discarded.
- CLR edge in the same cycle as a terminal event: the clear wins, with no irq and no flag set.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); operation resumes from IDLE after deassertion.

## Configuration
- COUNTER_IRQ_EN defined:
  - irq_o pulses on every terminal event while irqen_i[0]=1.
- Undefined:
  - irq_o is tied to 0 and the pulse logic is absent.
  - irqen_i is ignored.
  - All other behaviour is unchanged.

## Structure
- Package counter_pkg holds:
  - The FSM state enum.
  - CTRL bit indices (EN, DIR, ONESHOT, CLR).
  - STATUS bit indices (RUNNING, DONE, WRAPPED).
  - Register index constants 0–5, shared with the register bank.
- Sub-module counter_prescaler:
  - Inputs: clk, areset, run, clear, presc.
  - Output: tick.
  - Holds its value while run=0.

## Test plan
- Auto-reload: LOAD=0, LIMIT=3, PRESC=0, up, EN=1 → count 0,1,2,3,0,1…; WRAPPED=1 after the first 3→0 step; status 3'b101; irq_o pulses every 4 cycles (with macro).
- One-shot down: LOAD=5, LIMIT=2, PRESC=1, ONESHOT=1 → count 5,4,3,2, changing every 2 cycles; then status 3'b010; count holds at 2; EN=0 → IDLE with DONE=0.
- Pause/resume: EN dropped at count=7 → count holds at 7 and RUNNING=0 for 10 cycles; EN=1 → counting resumes at 8 on the expected tick.
- Soft clear: CLR rising edge during RUN with WRAPPED=1 → count=LOAD, status 3'b000, IDLE; CLR held high causes no further clears.
- Wrap-around: LOAD=32'hFFFFFFFE, LIMIT=1, up, PRESC=0 → count FFFFFFFE, FFFFFFFF, 0, 1, then reload.
- Async reset mid-run: areset low between clock edges → count_o=0 and status_o=0 immediately; after release, the FSM returns to RUN and reloads.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the counter engine and the register bank that drives it:
// FSM states, CTRL/STATUS bit positions and register slot indices.
package counter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_DIR     = 1;
   localparam int CTRL_ONESHOT = 2;
   localparam int CTRL_CLR     = 3;

   localparam int STAT_RUNNING = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_WRAPPED = 2;

   localparam int IRQEN_BIT    = 0;

   localparam int REG_CTRL     = 0;
   localparam int REG_LOAD     = 1;
   localparam int REG_LIMIT    = 2;
   localparam int REG_PRESC    = 3;
   localparam int REG_IRQEN    = 4;
   localparam int REG_STATUS   = 5;

endpackage

// File: rtl/counter_prescaler.sv
// Step prescaler: counts 0..presc while run=1 and flags the cycle on which a
// count step may happen; holds while run=0, clear forces it back to 0.
module counter_prescaler #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  areset,
   input  logic                  run,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] presc,
   output logic                  tick
);

   logic [DATA_WIDTH-1:0] cnt_q;

   // presc is compared live, so lowering it below cnt_q lets cnt_q run through
   // the full modulus before the next match.
   assign tick = run && (cnt_q == presc);

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (run) begin
         cnt_q <= tick ? '0 : cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/axi_counter_core.sv
// Programmable up/down counter engine behind the AXI register bank.
// Define COUNTER_IRQ_EN to build the terminal-count interrupt pulse on irq_o.
module axi_counter_core
   import counter_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  areset,
   input  logic [DATA_WIDTH-1:0] ctrl_i,
   input  logic [DATA_WIDTH-1:0] load_i,
   input  logic [DATA_WIDTH-1:0] limit_i,
   input  logic [DATA_WIDTH-1:0] presc_i,
   input  logic [DATA_WIDTH-1:0] irqen_i,
   output logic [2:0]            status_o,
   output logic [DATA_WIDTH-1:0] count_o,
   output logic                  irq_o,
   output state_e                dbg_state
);

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] count_q, count_d;
   logic                  done_q, done_d;
   logic                  wrapped_q, wrapped_d;
   logic                  clr_prev_q;
   logic                  clr_edge;
   logic                  en;
   logic                  presc_run;
   logic                  presc_clear;
   logic                  tick;
   logic                  terminal;

   assign en       = ctrl_i[CTRL_EN];
   assign clr_edge = ctrl_i[CTRL_CLR] && !clr_prev_q;

   // Prescaler only advances in RUN with EN held; leaving RUN freezes it for resume.
   assign presc_run   = (state_q == RUN) && en && !clr_edge;
   assign presc_clear = clr_edge || (state_q == IDLE) || (state_q == DONE);

   counter_prescaler #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_prescaler (
      .clk   (clk),
      .areset(areset),
      .run   (presc_run),
      .clear (presc_clear),
      .presc (presc_i),
      .tick  (tick)
   );

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      done_d    = done_q;
      wrapped_d = wrapped_q;
      terminal  = 1'b0;
      if (clr_edge) begin
         state_d   = IDLE;
         count_d   = load_i;
         done_d    = 1'b0;
         wrapped_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (en) begin
                  state_d = RUN;
                  count_d = load_i;
               end
            end
            RUN: begin
               if (!en) begin
                  state_d = PAUSE;
               end else if (tick) begin
                  if (count_q != limit_i) begin
                     count_d = ctrl_i[CTRL_DIR] ? count_q - 1'b1 : count_q + 1'b1;
                  end else begin
                     terminal = 1'b1;
                     if (ctrl_i[CTRL_ONESHOT]) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                     end else begin
                        count_d   = load_i;
                        wrapped_d = 1'b1;
                     end
                  end
               end
            end
            PAUSE: begin
               if (en) begin
                  state_d = RUN;
               end
            end
            DONE: begin
               if (!en) begin
                  state_d = IDLE;
                  done_d  = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         state_q    <= IDLE;
         count_q    <= '0;
         done_q     <= 1'b0;
         wrapped_q  <= 1'b0;
         clr_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         done_q     <= done_d;
         wrapped_q  <= wrapped_d;
         clr_prev_q <= ctrl_i[CTRL_CLR];
      end
   end

`ifdef COUNTER_IRQ_EN
   logic irq_q;

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= terminal && irqen_i[IRQEN_BIT];
      end
   end

   assign irq_o = irq_q;

   logic unused_bits;
   assign unused_bits = ^{ctrl_i[DATA_WIDTH-1:4], irqen_i[DATA_WIDTH-1:1]};
`else
   assign irq_o = 1'b0;

   logic unused_bits;
   assign unused_bits = ^{ctrl_i[DATA_WIDTH-1:4], irqen_i, terminal};
`endif

   assign count_o   = count_q;
   assign status_o  = {wrapped_q, done_q, (state_q == RUN)};
   assign dbg_state = state_q;

endmodule

// File: tb/tb_axi_counter_core.sv
// Directed bench for axi_counter_core: a per-cycle reference model checked every
// clock, plus literal expectations along each scenario.
module tb_axi_counter_core;
   import counter_pkg::*;

`ifdef COUNTER_IRQ_EN
   localparam bit IRQ_BUILT = 1'b1;
`else
   localparam bit IRQ_BUILT = 1'b0;
`endif

   localparam logic [1:0] MD_IDLE = 2'd0, MD_RUN = 2'd1, MD_PAUSE = 2'd2, MD_DONE = 2'd3;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        areset = 1'b0;
   logic [31:0] ctrl = '0, load = '0, limit = '0, presc = '0, irqen = '0;
   logic [2:0]  status;
   logic [31:0] count;
   logic        irq;
   state_e      dbg_state;

   always #5 clk = ~clk;

   axi_counter_core #(.DATA_WIDTH(32)) dut (
      .clk      (clk),
      .areset   (areset),
      .ctrl_i   (ctrl),
      .load_i   (load),
      .limit_i  (limit),
      .presc_i  (presc),
      .irqen_i  (irqen),
      .status_o (status),
      .count_o  (count),
      .irq_o    (irq),
      .dbg_state(dbg_state)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [1:0]  mode;
      logic [31:0] cnt;
      logic [31:0] since_step;
      logic        done;
      logic        wrapped;
      logic        irq;
      logic        clr_prev;
   } mdl_t;

   mdl_t mdl = '0;

   function automatic mdl_t mdl_next(input mdl_t m, input logic [31:0] c, input logic [31:0] ld,
                                     input logic [31:0] lim, input logic [31:0] ps,
                                     input logic [31:0] ie);
      mdl_t n = m;
      n.irq      = 1'b0;
      n.clr_prev = c[3];
      if (c[3] && !m.clr_prev) begin
         n.mode = MD_IDLE; n.cnt = ld; n.since_step = '0; n.done = 1'b0; n.wrapped = 1'b0;
         return n;
      end
      case (m.mode)
         MD_IDLE: if (c[0]) begin n.mode = MD_RUN; n.cnt = ld; n.since_step = '0; end
         MD_RUN: begin
            if (!c[0]) n.mode = MD_PAUSE;
            else if (m.since_step != ps) n.since_step = m.since_step + 1;
            else begin
               n.since_step = '0;
               if (m.cnt != lim) n.cnt = c[1] ? m.cnt - 1 : m.cnt + 1;
               else begin
                  n.irq = IRQ_BUILT && ie[0];
                  if (c[2]) begin n.mode = MD_DONE; n.done = 1'b1; end
                  else begin n.cnt = ld; n.wrapped = 1'b1; end
               end
            end
         end
         MD_PAUSE: if (c[0]) n.mode = MD_RUN;
         default: if (!c[0]) begin n.mode = MD_IDLE; n.done = 1'b0; end
      endcase
      return n;
   endfunction

   always @(posedge clk or negedge areset) begin
      if (!areset) mdl <= '0;
      else         mdl <= mdl_next(mdl, ctrl, load, limit, presc, irqen);
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      check("model_count", count, mdl.cnt);
      check("model_status", {29'd0, status}, {29'd0, mdl.wrapped, mdl.done, (mdl.mode == MD_RUN)});
      check("model_irq", {31'd0, irq}, {31'd0, mdl.irq});
   end

   // ---------------- driver ----------------
   task automatic cyc(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_out(input string name, input logic [31:0] c, input logic [2:0] s,
                             input logic i);
      #1;
      check({name, "_count"}, count, c);
      check({name, "_status"}, {29'd0, status}, {29'd0, s});
      check({name, "_irq"}, {31'd0, irq}, {31'd0, i});
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      irqen = 32'd1;
      #1;
      check("reset_state", {30'd0, dbg_state}, {30'd0, IDLE});
      expect_out("reset", 32'd0, 3'b000, 1'b0);
      cyc(2);
      areset = 1'b1;

      // auto-reload up, LOAD=0 LIMIT=3 PRESC=0
      load = 0; limit = 3; presc = 0; ctrl = 32'h1;
      for (int i = 0; i < 9; i++) begin
         cyc();
         expect_out("reload", i % 4, (i >= 4) ? 3'b101 : 3'b001, (i == 4 || i == 8) && IRQ_BUILT);
      end

      // soft clear while WRAPPED=1, CLR then held high
      load = 10; ctrl = 32'h9;
      cyc(); expect_out("clr_edge", 32'd10, 3'b000, 1'b0);
      cyc(); expect_out("clr_rerun", 32'd10, 3'b001, 1'b0);
      cyc(); expect_out("clr_held", 32'd11, 3'b001, 1'b0);
      ctrl = 32'h0;
      cyc(); expect_out("clr_pause", 32'd11, 3'b000, 1'b0);
      ctrl = 32'h8; cyc();
      ctrl = 32'h0; cyc();

      // one-shot down, LOAD=5 LIMIT=2 PRESC=1
      load = 5; limit = 2; presc = 1; ctrl = 32'h7;
      cyc(); expect_out("os_load", 32'd5, 3'b001, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         cyc(2); expect_out("os_step", 32'd5 - k, 3'b001, 1'b0);
      end
      cyc(); expect_out("os_wait", 32'd2, 3'b001, 1'b0);
      cyc(); expect_out("os_term", 32'd2, 3'b010, IRQ_BUILT);
      cyc(2); expect_out("os_hold", 32'd2, 3'b010, 1'b0);
      ctrl = 32'h0;
      cyc(); expect_out("os_idle", 32'd2, 3'b000, 1'b0);

      // pause at 7 for 10 cycles, resume on the expected tick
      load = 0; limit = 100; presc = 2; ctrl = 32'h1;
      cyc(); expect_out("pr_load", 32'd0, 3'b001, 1'b0);
      cyc(21); expect_out("pr_seven", 32'd7, 3'b001, 1'b0);
      ctrl = 32'h0;
      for (int k = 0; k < 10; k++) begin
         cyc(); expect_out("pr_paused", 32'd7, 3'b000, 1'b0);
      end
      ctrl = 32'h1;
      cyc(3); expect_out("pr_before", 32'd7, 3'b001, 1'b0);
      cyc(); expect_out("pr_resume", 32'd8, 3'b001, 1'b0);

      // CLR edge coinciding with a terminal event
      ctrl = 32'h8; cyc();
      ctrl = 32'h0; cyc();
      load = 0; limit = 1; presc = 0; ctrl = 32'h1;
      cyc(2); expect_out("ct_pre", 32'd1, 3'b001, 1'b0);
      ctrl = 32'h9;
      cyc(); expect_out("ct_clear", 32'd0, 3'b000, 1'b0);
      ctrl = 32'h0; cyc();

      // wrap through 2^32
      load = 32'hFFFF_FFFE; limit = 1; presc = 0; ctrl = 32'h1;
      cyc(); expect_out("wr_a", 32'hFFFF_FFFE, 3'b001, 1'b0);
      cyc(); expect_out("wr_b", 32'hFFFF_FFFF, 3'b001, 1'b0);
      cyc(); expect_out("wr_c", 32'd0, 3'b001, 1'b0);
      cyc(); expect_out("wr_d", 32'd1, 3'b001, 1'b0);
      cyc(); expect_out("wr_reload", 32'hFFFF_FFFE, 3'b101, IRQ_BUILT);

      // asynchronous reset between edges
      cyc(); #2;
      areset = 1'b0;
      #1; check("ar_state", {30'd0, dbg_state}, {30'd0, IDLE});
      expect_out("ar_now", 32'd0, 3'b000, 1'b0);
      cyc(); areset = 1'b1;
      cyc(); expect_out("ar_rerun", 32'hFFFF_FFFE, 3'b001, 1'b0);
      cyc(); expect_out("ar_step", 32'hFFFF_FFFF, 3'b001, 1'b0);

      cyc(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
